// File: rtl/error_feedback_accum.sv
// Error-diffusion accumulator: adds left and previous-line quantisation error to each pixel
// and builds the next line's error terms in a pair of ping-pong line buffers.
module error_feedback_accum #(
    parameter int LINE_WIDTH = 1024
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [7:0]         pix_in,
    input  logic               pix_sof,
    input  logic               pix_valid,
    output logic               pix_ready,
    output logic signed [10:0] sum_out,
    output logic               sum_valid,
    input  logic               sum_ready,
    input  logic signed [8:0]  qerr_in,
    input  logic               qerr_valid
);
    localparam int CW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(LINE_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, OUT, ERR, FLUSH} state_t;

    state_t            state;
    logic [CW-1:0]     col;
    logic signed [8:0] e_left;
    logic signed [8:0] e_left2;
    logic              first_line;
    logic              cur_bank;

    logic              err_take;
    logic              at_last;
    logic [CW-1:0]     rd_addr;
    logic [CW-1:0]     wr_addr;
    logic              wr_en;
    logic signed [12:0] wr_data;
    logic signed [12:0] rd_sel;

    assign err_take = (state == ERR) && qerr_valid;
    assign at_last  = (col == LAST_COL);

    // Read address runs one step ahead so cur[col] is already registered when IDLE is entered.
    always_comb begin
        rd_addr = col;
        if (err_take && !at_last)
            rd_addr = col + CW'(1);
        else if (state == FLUSH)
            rd_addr = '0;
    end

    logic signed [12:0] el2_x;
    logic signed [12:0] el_x;
    logic signed [12:0] q_x;
    assign el2_x = {{4{e_left2[8]}}, e_left2};
    assign el_x  = {{4{e_left[8]}}, e_left};
    assign q_x   = {{4{qerr_in[8]}}, qerr_in};

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = col - CW'(1);
        wr_data = el2_x + 13'sd5 * el_x + 13'sd3 * q_x;
        if (err_take && (col != '0)) begin
            wr_en = 1'b1;
        end else if (state == FLUSH) begin
            wr_en   = 1'b1;
            wr_addr = LAST_COL;
            wr_data = el2_x + 13'sd5 * el_x;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : bank_g
            logic signed [12:0] mem [LINE_WIDTH];
            logic signed [12:0] rd_q;
            always_ff @(posedge clk) begin
                if (wr_en && (cur_bank != 1'(gi)))
                    mem[wr_addr] <= wr_data;
                rd_q <= mem[rd_addr];
            end
        end
    endgenerate

    assign rd_sel = cur_bank ? bank_g[1].rd_q : bank_g[0].rd_q;

    logic signed [8:0]  e_use;
    logic signed [13:0] e14;
    logic signed [13:0] cur14;
    logic signed [13:0] acc;
    logic signed [10:0] sh_val;
    logic signed [10:0] pix_s;
    logic signed [10:0] sum_next;

    // A start-of-frame pixel ignores both the carried left error and the old line buffer.
    assign e_use    = pix_sof ? 9'sd0 : e_left;
    assign e14      = {{5{e_use[8]}}, e_use};
    assign cur14    = (pix_sof || first_line) ? 14'sd0 : {rd_sel[12], rd_sel};
    assign acc      = 14'sd7 * e14 + cur14;
    assign sh_val   = 11'(acc >>> 4);
    assign pix_s    = {3'b000, pix_in};
    assign sum_next = pix_s + sh_val;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            pix_ready  <= 1'b1;
            sum_valid  <= 1'b0;
            sum_out    <= '0;
            col        <= '0;
            e_left     <= '0;
            e_left2    <= '0;
            first_line <= 1'b1;
            cur_bank   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pix_valid) begin
                        sum_out   <= sum_next;
                        sum_valid <= 1'b1;
                        pix_ready <= 1'b0;
                        state     <= OUT;
                        if (pix_sof) begin
                            col        <= '0;
                            e_left     <= '0;
                            e_left2    <= '0;
                            first_line <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (sum_ready) begin
                        sum_valid <= 1'b0;
                        state     <= ERR;
                    end
                end
                ERR: begin
                    if (qerr_valid) begin
                        e_left2 <= e_left;
                        e_left  <= qerr_in;
                        if (at_last) begin
                            state <= FLUSH;
                        end else begin
                            col       <= col + CW'(1);
                            state     <= IDLE;
                            pix_ready <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    col        <= '0;
                    e_left     <= '0;
                    e_left2    <= '0;
                    first_line <= 1'b0;
                    cur_bank   <= ~cur_bank;
                    state      <= IDLE;
                    pix_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_error_feedback_accum.sv
// Directed bench for error_feedback_accum with a line-level error-diffusion reference model.
module tb_error_feedback_accum;
    localparam int W     = 4;
    localparam int NOLIT = 99999;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  pix_in = '0;
    logic        pix_sof = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [10:0] sum_out;
    logic        sum_valid;
    logic        sum_ready = 1'b0;
    logic [8:0]  qerr_in = '0;
    logic        qerr_valid = 1'b0;

    int tests = 0;
    int fails = 0;

    // Reference model state: errors of the previous completed line and the one in progress.
    int prev_err [W];
    int cur_err [W];
    bit have_prev = 1'b0;
    int mcol = 0;
    int m_eleft = 0;
    int exp_sum = 0;
    bit exp_active = 1'b0;

    error_feedback_accum #(.LINE_WIDTH(W)) dut (
        .clk(clk), .rstn(rstn),
        .pix_in(pix_in), .pix_sof(pix_sof), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .sum_out(sum_out), .sum_valid(sum_valid), .sum_ready(sum_ready),
        .qerr_in(qerr_in), .qerr_valid(qerr_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int floor16(input int a);
        if (a >= 0) return a / 16;
        return -((-a + 15) / 16);
    endfunction

    task automatic model_reset();
        mcol = 0;
        m_eleft = 0;
        have_prev = 1'b0;
    endtask

    task automatic model_pixel(input int p, input bit sof);
        int c;
        if (sof) begin
            mcol = 0;
            m_eleft = 0;
            have_prev = 1'b0;
        end
        c = 0;
        if (have_prev) begin
            if (mcol > 0) c += prev_err[mcol-1];
            c += 5 * prev_err[mcol];
            if (mcol < W - 1) c += 3 * prev_err[mcol+1];
        end
        exp_sum = p + floor16(7 * m_eleft + c);
    endtask

    task automatic model_err(input int q);
        cur_err[mcol] = q;
        m_eleft = q;
        if (mcol == W - 1) begin
            prev_err = cur_err;
            have_prev = 1'b1;
            mcol = 0;
            m_eleft = 0;
        end else begin
            mcol++;
        end
    endtask

    // Compare process: every cycle the outputs are checked against the model's view.
    always @(negedge clk) begin
        if (!rstn) begin
            check("rst_sum_valid", int'(sum_valid), 0);
            check("rst_sum_out", int'($signed(sum_out)), 0);
            check("rst_pix_ready", int'(pix_ready), 1);
        end else if (exp_active) begin
            check("out_sum_valid", int'(sum_valid), 1);
            check("out_sum", int'($signed(sum_out)), exp_sum);
            check("out_pix_ready", int'(pix_ready), 0);
        end else begin
            check("quiet_sum_valid", int'(sum_valid), 0);
        end
    end

    task automatic xfer(input int p, input bit sof, input int stall, input int lit);
        int n;
        @(negedge clk);
        n = 0;
        while (pix_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("pix_ready_idle", int'(pix_ready), 1);
        pix_in = 8'(p);
        pix_sof = sof;
        pix_valid = 1'b1;
        model_pixel(p, sof);
        @(posedge clk); #1;
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        exp_active = 1'b1;
        @(negedge clk);
        check("latency", int'(sum_valid), 1);
        if (lit != NOLIT) check("literal", int'($signed(sum_out)), lit);
        $display("[TB] pix %0d sof %0d col %0d -> sum %0d (model %0d)",
                 p, sof, mcol, $signed(sum_out), exp_sum);
        for (int i = 0; i < stall; i++) begin
            qerr_in = 9'h0AB;
            qerr_valid = (i == 0);
            @(negedge clk);
        end
        qerr_valid = 1'b0;
        sum_ready = 1'b1;
        @(posedge clk); #1;
        sum_ready = 1'b0;
        exp_active = 1'b0;
    endtask

    task automatic give_err(input int q);
        qerr_in = 9'(q);
        qerr_valid = 1'b1;
        @(negedge clk);
        check("pix_ready_err", int'(pix_ready), 0);
        @(posedge clk); #1;
        qerr_valid = 1'b0;
        model_err(q);
    endtask

    task automatic send(input int p, input bit sof, input int q, input int stall, input int lit);
        xfer(p, sof, stall, lit);
        give_err(q);
    endtask

    initial begin
        foreach (prev_err[i]) begin
            prev_err[i] = 0;
            cur_err[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Plain pass-through on a fresh frame
        send(10, 1, 0, 0, 10);
        send(20, 0, 0, 0, 20);
        send(30, 0, 0, 0, 30);

        // Left-neighbour error only
        send(100, 1, 16, 0, 100);
        send(50, 0, 0, 0, 57);

        // Full line of errors feeding the next line; stalled output on one pixel
        send(0, 1, 16, 0, 0);
        send(0, 0, 16, 0, 7);
        send(0, 0, 16, 0, 7);
        send(0, 0, 16, 0, 7);
        send(0, 0, 0, 0, 8);
        send(0, 0, 0, 3, 9);
        send(0, 0, 0, 0, 9);
        send(0, 0, 0, 0, 6);

        // Negative floor
        send(0, 1, -1, 0, 0);
        send(0, 0, 0, 0, -1);

        // Mixed extreme errors over three lines
        send(200, 1, 255, 0, 200);
        send(3, 0, -256, 0, NOLIT);
        send(128, 0, 37, 0, NOLIT);
        send(77, 0, -5, 0, NOLIT);
        send(255, 0, -100, 0, 286);
        send(0, 0, 50, 0, -101);
        send(12, 0, 0, 2, NOLIT);
        send(250, 0, 7, 0, NOLIT);
        send(128, 0, 0, 0, NOLIT);
        send(60, 0, -30, 1, NOLIT);

        // Reset while waiting for the error: drops the sum and restarts a frame
        xfer(77, 1, 0, 77);
        rstn = 1'b0;
        model_reset();
        @(negedge clk);
        @(posedge clk); #1;
        rstn = 1'b1;
        send(40, 0, 0, 0, 40);
        send(90, 0, 5, 0, NOLIT);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/error_feedback_accum.md
ERROR_FEEDBACK_ACCUM -- requirements
Module: error_feedback_accum

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 1024: pixels per line; legal range 2..4096.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port pix_in  input  8  unsigned grey pixel.
REQ-005 SHALL have port pix_sof  input  1  qualifies pix_in as the first pixel of a frame.
REQ-006 SHALL have port pix_valid  input  1  pixel present.
REQ-007 SHALL have port pix_ready  output  1  block accepts the pixel this cycle.
REQ-008 SHALL have port sum_out  output  11  signed pixel+diffused-error sum, sent to the downstream clamp/quantizer.
REQ-009 SHALL have port sum_valid  output  1  sum_out valid.
REQ-010 SHALL have port sum_ready  input  1  downstream accepts sum_out.
REQ-011 SHALL have port qerr_in  input  9  signed quantisation error returned for the last sum, range -256..255.
REQ-012 SHALL have port qerr_valid  input  1  qerr_in valid.

Function
REQ-013 SHALL implement a state machine with states IDLE, OUT, ERR, FLUSH.
REQ-014 IDLE: pix_ready=1; a pixel transfer (pix_valid&pix_ready) registers sum_out and moves to OUT; otherwise stay.
REQ-015 OUT: sum_valid=1, sum_out held stable; sum_valid&sum_ready moves to ERR.
REQ-016 ERR: waits for qerr_valid; on it, applies the error (REQ-019..021), then goes to FLUSH if the column was LINE_WIDTH-1, else IDLE.
REQ-017 FLUSH: one cycle; writes the last next-line entry, swaps line buffers, clears column to 0 and e_left to 0, returns to IDLE.
REQ-018 qerr_valid outside ERR SHALL be ignored; pix_ready SHALL be 0 in OUT, ERR, FLUSH.
REQ-019 Sum at column x: sum_out = pix_in + ((7*e_left + cur[x]) >>> 4), arithmetic shift (floor); intermediate 14-bit signed, result 11-bit signed, no saturation needed.
REQ-020 e_left = qerr of column x-1 on the same line; 0 at column 0.
REQ-021 Next-line buffer entry nxt[x] (13-bit signed) SHALL finalise as 1*e(x-1) + 5*e(x) + 3*e(x+1); terms with columns outside 0..LINE_WIDTH-1 are zero; nxt[x-1] written on receipt of e(x), nxt[LINE_WIDTH-1] written in FLUSH.
REQ-022 Two ping-pong buffers of LINE_WIDTH x 13 bits; cur is read, nxt is written; roles swap in FLUSH.
REQ-023 First line after reset or after a pix_sof transfer: cur[x] SHALL read as 0 for every x.
REQ-024 pix_sof transfer SHALL force column 0 and e_left 0 for that pixel regardless of prior position; a partial previous line is discarded without FLUSH.
REQ-025 Latency: sum_valid asserts the cycle after the pixel transfer; throughput at most one pixel per 3 cycles (4 at line end).

Reset
REQ-026 While rstn=0: state IDLE, pix_ready=1, sum_valid=0, sum_out=0, column=0, e_left=0, first-line flag set; buffer contents need not be cleared.
REQ-027 Reset deassertion mid-line SHALL resume as a fresh frame; any in-flight sum is dropped.

Verification (LINE_WIDTH=4)
REQ-028 Pixels 10,20,30 with sof on first, qerr 0 each -> sum_out 10,20,30, each one cycle after transfer.
REQ-029 pix 100 (sof), qerr 16; pix 50 -> sum_out 57 (50 + 112>>>4).
REQ-030 Line 0 all qerr 16; line 1 pixels 0, qerr 0 -> sums 8, 9, 9, 6 (cur = 128, 144, 144, 96).
REQ-031 pix 0 (sof), qerr -1; pix 0 -> sum_out 11'h7FF (-1, floor of -7/16).
REQ-032 sum_ready held 0 for 3 cycles in OUT -> sum_out and sum_valid stable, pix_ready 0 throughout; qerr_valid pulsed during OUT has no effect.
REQ-033 rstn pulsed low in ERR -> next cycle outputs at reset values; following pixel 40 without sof -> sum_out 40.
